// File: rtl/bit_serial_pkg.sv
// Shared definitions for the bit-serial adder: FSM state encodings and default sizes.
package bit_serial_pkg;

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FIN  = 2'd2
  } state_e;

endpackage

// File: rtl/bit_serial_shreg.sv
// Parallel-load, right-shift register; serial input enters at the MSB.
module bit_serial_shreg
  import bit_serial_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] par_in,
  input  logic             ser_in,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  always_comb begin
    q_d = q_q;
    if (load) begin
      q_d = par_in;
    end else if (shift) begin
      q_d = {ser_in, q_q[WIDTH-1:1]};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/fulladder.sv
// 1-bit full adder cell (C,B,A -> Sum,Carry); purely combinational.
module fulladder (
  input  logic C,
  input  logic B,
  input  logic A,
  output logic Sum,
  output logic Carry
);

  assign Sum   = A ^ B ^ C;
  assign Carry = (A & B) | (C & (A ^ B));

endmodule

// File: rtl/bit_serial_adder.sv
// Bit-serial adder: feeds one operand bit pair per clock (LSB first) through a fulladder cell.
// Optional macro SUBTRACT_EN adds a Sub input that turns the operation into OpA - OpB.
module bit_serial_adder
  import bit_serial_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CNT_W = DEFAULT_CNT_W
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             Start,
  input  logic [WIDTH-1:0] OpA,
  input  logic [WIDTH-1:0] OpB,
  input  logic             CarryIn,
`ifdef SUBTRACT_EN
  input  logic             Sub,
`endif
  output logic             Busy,
  output logic             Done,
  output logic             SerialSum,
  output logic [WIDTH-1:0] Result,
  output logic             CarryOut
);

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             ssum_q, ssum_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             cout_q, cout_d;

  logic [WIDTH-1:0] a_q, b_q, sum_q;
  logic             accept, run, last;
  logic             cin_eff, b_bit;
  logic             fa_sum, fa_carry;
  logic             unused_bits;

  // A new add is only taken when no bits are in flight.
  assign accept = Start && ((state_q == ST_IDLE) || (state_q == ST_FIN));
  assign run    = (state_q == ST_RUN);
  assign last   = run && (cnt_q == LAST_BIT);

`ifdef SUBTRACT_EN
  logic sub_q, sub_d;

  assign cin_eff = Sub ? 1'b1 : CarryIn;
  assign b_bit   = b_q[0] ^ sub_q;
  assign sub_d   = accept ? Sub : sub_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sub_q <= 1'b0;
    end else begin
      sub_q <= sub_d;
    end
  end
`else
  assign cin_eff = CarryIn;
  assign b_bit   = b_q[0];
`endif

  bit_serial_shreg #(.WIDTH(WIDTH)) u_shreg_a (
    .clk    (CLK),
    .rst    (RST),
    .load   (accept),
    .shift  (run),
    .par_in (OpA),
    .ser_in (1'b0),
    .q      (a_q)
  );

  bit_serial_shreg #(.WIDTH(WIDTH)) u_shreg_b (
    .clk    (CLK),
    .rst    (RST),
    .load   (accept),
    .shift  (run),
    .par_in (OpB),
    .ser_in (1'b0),
    .q      (b_q)
  );

  bit_serial_shreg #(.WIDTH(WIDTH)) u_shreg_sum (
    .clk    (CLK),
    .rst    (RST),
    .load   (accept),
    .shift  (run),
    .par_in ('0),
    .ser_in (fa_sum),
    .q      (sum_q)
  );

  fulladder u_fa (
    .C     (carry_q),
    .B     (b_bit),
    .A     (a_q[0]),
    .Sum   (fa_sum),
    .Carry (fa_carry)
  );

  // Only the LSBs of the operand shifters feed the cell.
  assign unused_bits = ^{a_q[WIDTH-1:1], b_q[WIDTH-1:1], sum_q[0]};

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    carry_d  = carry_q;
    ssum_d   = ssum_q;
    result_d = result_q;
    cout_d   = cout_q;

    case (state_q)
      ST_IDLE: if (Start) state_d = ST_RUN;
      ST_RUN:  if (cnt_q == LAST_BIT) state_d = ST_FIN;
      ST_FIN:  state_d = Start ? ST_RUN : ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    if (accept) begin
      cnt_d   = '0;
      carry_d = cin_eff;
    end else if (run) begin
      cnt_d   = cnt_q + 1'b1;
      carry_d = fa_carry;
      ssum_d  = fa_sum;
      // Final bit lands in Result alongside the bits already shifted in.
      if (last) begin
        result_d = {fa_sum, sum_q[WIDTH-1:1]};
        cout_d   = fa_carry;
      end
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
      ssum_q   <= 1'b0;
      result_q <= '0;
      cout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      carry_q  <= carry_d;
      ssum_q   <= ssum_d;
      result_q <= result_d;
      cout_q   <= cout_d;
    end
  end

  assign Busy      = (state_q == ST_RUN);
  assign Done      = (state_q == ST_FIN);
  assign SerialSum = ssum_q;
  assign Result    = result_q;
  assign CarryOut  = cout_q;

endmodule

// File: tb/tb_bit_serial_adder.sv
// Randomized self-checking bench for bit_serial_adder (WIDTH=8) against an arithmetic model.
module tb_bit_serial_adder;

  logic       CLK = 1'b0;
  logic       RST;
  logic       Start;
  logic [7:0] OpA, OpB;
  logic       CarryIn;
`ifdef SUBTRACT_EN
  logic       Sub;
`endif
  logic       Busy, Done, SerialSum, CarryOut;
  logic [7:0] Result;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  bit_serial_adder #(.WIDTH(8), .CNT_W(4)) dut (
    .CLK       (CLK),
    .RST       (RST),
    .Start     (Start),
    .OpA       (OpA),
    .OpB       (OpB),
    .CarryIn   (CarryIn),
`ifdef SUBTRACT_EN
    .Sub       (Sub),
`endif
    .Busy      (Busy),
    .Done      (Done),
    .SerialSum (SerialSum),
    .Result    (Result),
    .CarryOut  (CarryOut)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_ops(input logic [7:0] a, input logic [7:0] b, input logic cin, input logic sub);
    OpA = a;
    OpB = b;
    CarryIn = cin;
`ifdef SUBTRACT_EN
    Sub = sub;
`else
    if (sub) $display("note: subtract requested in add-only build");
`endif
  endtask

  // One complete transaction; poke raises Start mid-run, which must be ignored.
  task automatic run_add(input logic [7:0] a, input logic [7:0] b, input logic cin,
                         input logic sub, input bit poke);
    logic [8:0] exp;
    if (sub) exp = {(a >= b), 8'(a - b)};
    else     exp = 9'(a) + 9'(b) + 9'(cin);
    @(negedge CLK);
    drive_ops(a, b, cin, sub);
    Start = 1'b1;
    @(posedge CLK);
    #1;
    Start = 1'b0;
    drive_ops(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom) & sub);
    for (int i = 0; i < 8; i++) begin
      @(negedge CLK);
      check("busy_run", Busy, 1);
      check("done_run", Done, 0);
      Start = poke && (i == 3);
      @(posedge CLK);
      #1;
      Start = 1'b0;
      check($sformatf("serial_bit%0d", i), SerialSum, exp[i]);
    end
    check("done_pulse", Done, 1);
    check("busy_fin", Busy, 0);
    check("result", Result, exp[7:0]);
    check("carry_out", CarryOut, exp[8]);
    @(posedge CLK);
    #1;
    check("done_clear", Done, 0);
    check("busy_idle", Busy, 0);
    check("result_hold", Result, exp[7:0]);
  endtask

  initial begin
    RST = 1'b1;
    Start = 1'b0;
    drive_ops(8'h00, 8'h00, 1'b0, 1'b0);
    #12;
    check("rst_busy", Busy, 0);
    check("rst_done", Done, 0);
    check("rst_serial", SerialSum, 0);
    check("rst_result", Result, 0);
    check("rst_cout", CarryOut, 0);
    @(negedge CLK);
    RST = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge CLK);
      check("idle_busy", Busy, 0);
      check("idle_done", Done, 0);
    end

    run_add(8'h5A, 8'h3C, 1'b0, 1'b0, 1'b0);
    run_add(8'hFF, 8'h00, 1'b1, 1'b0, 1'b0);

    // Start held high: second add accepted straight out of FIN.
    @(negedge CLK);
    drive_ops(8'h01, 8'h01, 1'b0, 1'b0);
    Start = 1'b1;
    @(posedge CLK);
    #1;
    drive_ops(8'h80, 8'h80, 1'b0, 1'b0);
    repeat (8) @(posedge CLK);
    #1;
    check("b2b_done1", Done, 1);
    check("b2b_res1", Result, 8'h02);
    check("b2b_cout1", CarryOut, 0);
    @(posedge CLK);
    #1;
    Start = 1'b0;
    check("b2b_busy2", Busy, 1);
    check("b2b_nodone", Done, 0);
    repeat (8) @(posedge CLK);
    #1;
    check("b2b_done2", Done, 1);
    check("b2b_res2", Result, 8'h00);
    check("b2b_cout2", CarryOut, 1);
    @(posedge CLK);

    for (int n = 0; n < 25; n++) begin
      run_add(8'($urandom), 8'($urandom), 1'($urandom), 1'b0, bit'($urandom_range(0, 1)));
    end

    // Abort mid-add with an asynchronous reset.
    run_add(8'h77, 8'h22, 1'b1, 1'b0, 1'b0);
    @(negedge CLK);
    drive_ops(8'h0F, 8'h01, 1'b0, 1'b0);
    Start = 1'b1;
    @(posedge CLK);
    #1;
    Start = 1'b0;
    repeat (4) @(posedge CLK);
    #2;
    RST = 1'b1;
    #1;
    check("abort_busy", Busy, 0);
    check("abort_done", Done, 0);
    check("abort_serial", SerialSum, 0);
    check("abort_result", Result, 0);
    check("abort_cout", CarryOut, 0);
    @(negedge CLK);
    RST = 1'b0;
    run_add(8'h0F, 8'h01, 1'b0, 1'b0, 1'b0);

`ifdef SUBTRACT_EN
    run_add(8'h10, 8'h01, 1'b0, 1'b1, 1'b0);
    run_add(8'h00, 8'h01, 1'b1, 1'b1, 1'b0);
    for (int n = 0; n < 10; n++) begin
      run_add(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom), 1'b0);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
